// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles little-endian words into instruction memory
// and holds the CPU in reset until a load succeeds. Optional trailer check: CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_W = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] word_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;
`ifdef CHECKSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd6;
`endif

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  logic [2:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] n_q, n_d;
  logic [31:0] asm_q, asm_d;
  logic [15:0] wc_q, wc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
`ifdef CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
`endif

  logic        fire;
  logic [31:0] full_word;
  logic [15:0] hdr_n;

  assign fire      = rx_valid && rx_ready;
  // Byte 3 completes a word, so it is merged straight from rx_data.
  assign full_word = {rx_data, asm_q[23:0]};
  assign hdr_n     = {rx_data, n_q[7:0]};

  always_comb begin
    rx_ready = (state_q == S_HDR) || (state_q == S_DATA);
    busy     = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_WRITE);
`ifdef CHECKSUM_EN
    if (state_q == S_CSUM) begin
      rx_ready = 1'b1;
      busy     = 1'b1;
    end
`endif
  end

  assign imem_we    = (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign cpu_reset  = (state_q != S_DONE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_count = wc_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    asm_d   = asm_q;
    wc_d    = wc_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
          idx_d   = 2'd0;
          wc_d    = 16'd0;
`ifdef CHECKSUM_EN
          sum_d   = 32'd0;
`endif
        end
      end
      S_HDR: begin
        if (fire) begin
          if (idx_q == 2'd0) begin
            n_d[7:0] = rx_data;
            idx_d    = 2'd1;
          end else begin
            n_d   = hdr_n;
            idx_d = 2'd0;
            if (hdr_n == 16'd0 || {1'b0, hdr_n} > MAX_WORDS) begin
              state_d = S_ERR;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (fire) begin
          asm_d[8*idx_q +: 8] = rx_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
            addr_d  = {{(30-ADDR_W){1'b0}}, wc_q[ADDR_W-1:0], 2'b00};
            wdata_d = full_word;
          end
        end
      end
      S_WRITE: begin
        wc_d = wc_q + 16'd1;
`ifdef CHECKSUM_EN
        sum_d = sum_q + wdata_q;
        state_d = (wc_q + 16'd1 == n_q) ? S_CSUM : S_DATA;
`else
        state_d = (wc_q + 16'd1 == n_q) ? S_DONE : S_DATA;
`endif
      end
`ifdef CHECKSUM_EN
      S_CSUM: begin
        if (fire) begin
          asm_d[8*idx_q +: 8] = rx_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = (full_word == sum_q) ? S_DONE : S_ERR;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      n_q     <= 16'd0;
      asm_q   <= 32'd0;
      wc_q    <= 16'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
`ifdef CHECKSUM_EN
      sum_q   <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      asm_q   <= asm_d;
      wc_q    <= wc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected writes queued at stimulus time, checked by a
// negedge monitor as the loader emits them.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, imem_we, cpu_reset, busy, done, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] word_count;

  int compared = 0;
  int mismatched = 0;
  int we_cycles = 0;
  int bytes_acc = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_w;
  logic [31:0] wq[$];

  prog_loader #(.ADDR_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) bytes_acc++;
      if (imem_we) begin
        we_cycles++;
        $display("write addr %h data %h", imem_addr, imem_wdata);
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $error("FAIL unexpected_write: observed addr %h data %h expected no write", imem_addr, imem_wdata);
        end else begin
          exp_w = sb.pop_front();
          chk("imem_write", {imem_addr, imem_wdata}, exp_w);
        end
        chk("ready_low_in_write", 64'(rx_ready), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int waited = 0;
    if (stall) begin
      rx_valid = 1'b0;
      rx_data  = 8'hA5;
      tick();
    end
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (waited >= 100) begin
      compared++;
      mismatched++;
      $error("FAIL rx_ready_timeout: observed ready=0 for %0d cycles expected ready=1", waited);
    end
    tick();
    rx_valid = 1'b0;
  endtask

  // Loads the words in wq and checks writes, end timing and final status.
  task automatic do_load(input bit stall);
    int n = wq.size();
    int we0 = we_cycles;
    int b0 = bytes_acc;
    logic [15:0] nn = 16'(n);
    logic [31:0] sum = 32'd0;
    logic [31:0] w;
    pulse_start();
    chk("load_start", {60'd0, rx_ready, busy, cpu_reset, done}, {60'd0, 4'b1110});
    send_byte(nn[7:0], stall);
    send_byte(nn[15:8], stall);
    for (int i = 0; i < n; i++) begin
      w = wq[i];
      sb.push_back({32'(i * 4), w});
      sum = sum + w;
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], stall);
    end
`ifdef CHECKSUM_EN
    for (int k = 0; k < 4; k++) send_byte(sum[8*k +: 8], stall);
    chk("final_state", {60'd0, done, err, cpu_reset, busy}, {60'd0, 4'b1000});
    chk("byte_count", 64'(bytes_acc - b0), 64'(2 + 4 * n + 4));
`else
    chk("last_write_cycle", {62'd0, imem_we, done}, {62'd0, 2'b10});
    tick();
    chk("final_state", {60'd0, done, err, cpu_reset, busy}, {60'd0, 4'b1000});
    chk("byte_count", 64'(bytes_acc - b0), 64'(2 + 4 * n));
`endif
    chk("word_count", 64'(word_count), 64'(n));
    chk("we_cycles", 64'(we_cycles - we0), 64'(n));
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int we0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_outputs", {42'd0, cpu_reset, rx_ready, imem_we, busy, done, err, word_count},
        {42'd0, 6'b100000, 16'h0000});
    chk("reset_addr_data", {imem_addr, imem_wdata}, 64'd0);
    for (int i = 0; i < 20; i++) begin
      chk("idle_hold", {60'd0, cpu_reset, rx_ready, done, err}, {60'd0, 4'b1000});
      tick();
    end

    // Two-word program, no stalls, then the same with rx_valid toggling.
    wq.delete();
    wq.push_back(32'hE3A00003);
    wq.push_back(32'hE3A01004);
    do_load(1'b0);
    do_load(1'b1);

    // Header one above capacity, then zero words: both rejected without writes.
    we0 = we_cycles;
    pulse_start();
    chk("restart_cpu_reset", 64'(cpu_reset), 64'd1);
    send_byte(8'h41, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("hdr_too_big", {59'd0, err, done, cpu_reset, rx_ready, busy}, {59'd0, 5'b10100});
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("hdr_zero", {59'd0, err, done, cpu_reset, rx_ready, busy}, {59'd0, 5'b10100});
    chk("no_write_on_hdr_err", 64'(we_cycles - we0), 64'd0);

    // Full capacity: 64 random words, last address 0xFC.
    wq.delete();
    for (int i = 0; i < 64; i++) wq.push_back($urandom);
    do_load(1'b0);

`ifdef CHECKSUM_EN
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    sb.push_back({32'h0, 32'h00000001});
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    chk("csum_bad", {61'd0, err, done, cpu_reset}, {61'd0, 3'b101});
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    sb.push_back({32'h0, 32'h00000001});
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    chk("csum_good", {61'd0, err, done, cpu_reset}, {61'd0, 3'b010});
`endif

    // Reset after three data bytes discards the partial word.
    we0 = we_cycles;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    reset = 1'b1;
    tick();
    chk("midload_reset_outputs", {42'd0, cpu_reset, rx_ready, imem_we, busy, done, err, word_count},
        {42'd0, 6'b100000, 16'h0000});
    chk("midload_reset_addr_data", {imem_addr, imem_wdata}, 64'd0);
    reset = 1'b0;
    tick();
    chk("midload_no_write", 64'(we_cycles - we0), 64'd0);
    wq.delete();
    wq.push_back(32'hE3A00003);
    wq.push_back(32'hE3A01004);
    do_load(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
